// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port dmem between requester 0 (CPU) and requester 1 (DMA)
// Ports: clock/reset (async active-low); per requester rX_req/we/lock/addr/wdata in,
// rX_gnt/rX_rvalid/rX_rdata out; mem_address/mem_data/mem_wren to dmem, mem_q from dmem.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tag_v_q, tag_v_d, tag_id_q, tag_id_d;
  logic       own_req, g0, g1, gnt, lock_g, we_g, release_lock;
  logic [7:0] cnt_inc;
  always_comb begin
    // A locked owner that still requests keeps the port; otherwise arbitrate as if idle.
    own_req      = (state_q == OWN0 && r0_req) || (state_q == OWN1 && r1_req);
    g0           = reset && (own_req ? state_q == OWN0 : r0_req && (!r1_req || !ptr_q));
    g1           = reset && (own_req ? state_q == OWN1 : r1_req && (!r0_req || ptr_q));
    gnt          = g0 || g1;
    lock_g       = g0 ? r0_lock : r1_lock;
    we_g         = g0 ? r0_we : r1_we;
    // Counter holds the number of locked cycles already granted; release when this one is the last.
    cnt_inc      = (own_req ? cnt_q : 8'd0) + 8'd1;
    release_lock = !gnt || !lock_g || cnt_inc == 8'(MAX_LOCK);
    state_d      = release_lock ? IDLE : (g0 ? OWN0 : OWN1);
    cnt_d        = release_lock ? 8'd0 : cnt_inc;
    // ptr=1 means requester 1 wins the next contention; it always points away from the last grant.
    ptr_d        = gnt ? g0 : ptr_q;
    tag_v_d      = gnt && !we_g;
    tag_id_d     = g1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= 8'd0;
      tag_v_q  <= 1'b0;
      tag_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end
  assign r0_gnt      = g0;
  assign r1_gnt      = g1;
  assign mem_address = g0 ? r0_addr : (g1 ? r1_addr : '0);
  assign mem_data    = g0 ? r0_wdata : (g1 ? r1_wdata : '0);
  assign mem_wren    = gnt && we_g;
  assign r0_rvalid   = tag_v_q && !tag_id_q;
  assign r1_rvalid   = tag_v_q && tag_id_q;
  assign r0_rdata    = r0_rvalid ? mem_q : '0;
  assign r1_rdata    = r1_rvalid ? mem_q : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench with read-response scoreboard for dmem_port_arbiter
module tb_dmem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [11:0] r0_addr, r1_addr, mem_address;
  logic [31:0] r0_wdata, r1_wdata, mem_data, mem_q, r0_rdata, r1_rdata;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_wren;
  logic [31:0] mem [0:4095];
  logic [32:0] sb [$];
  int          n_chk = 0, n_fail = 0;

  dmem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Synchronous single-port dmem model: read data appears the cycle after the address.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pops the oldest expected read response.
  always @(negedge clock) begin
    logic [32:0] e;
    if (reset) begin
      chk("one_gnt", {63'd0, r0_gnt && r1_gnt}, 64'd0);
      chk("one_rvalid", {63'd0, r0_rvalid && r1_rvalid}, 64'd0);
      if (r0_rvalid || r1_rvalid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rvalid_unexpected: got r0_rvalid=%0b r1_rvalid=%0b, expected none at %0t",
                   r0_rvalid, r1_rvalid, $time);
        end else begin
          e = sb.pop_front();
          chk("rvalid_id", {63'd0, r1_rvalid}, {63'd0, e[32]});
          chk("rdata", {32'd0, r1_rvalid ? r1_rdata : r0_rdata}, {32'd0, e[31:0]});
          chk("other_rdata_zero", {32'd0, r1_rvalid ? r0_rdata : r1_rdata}, 64'd0);
        end
      end
    end
  end

  task automatic set0(input logic q, input logic w, input logic l, input logic [11:0] a, input logic [31:0] d);
    r0_req = q; r0_we = w; r0_lock = l; r0_addr = a; r0_wdata = d;
  endtask

  task automatic set1(input logic q, input logic w, input logic l, input logic [11:0] a, input logic [31:0] d);
    r1_req = q; r1_we = w; r1_lock = l; r1_addr = a; r1_wdata = d;
  endtask

  // One cycle: check grant and dmem drive, queue expected read data for the monitor.
  task automatic step(input logic [1:0] eg, input logic [31:0] ed);
    logic w;
    @(negedge clock);
    chk("gnt", {62'd0, r1_gnt, r0_gnt}, {62'd0, eg});
    if (eg != 2'b00) begin
      w = eg[0] ? r0_we : r1_we;
      chk("mem_address", {52'd0, mem_address}, {52'd0, eg[0] ? r0_addr : r1_addr});
      chk("mem_wren", {63'd0, mem_wren}, {63'd0, w});
      if (w) chk("mem_data", {32'd0, mem_data}, {32'd0, eg[0] ? r0_wdata : r1_wdata});
      else sb.push_back({eg[1], ed});
    end else begin
      chk("mem_wren_idle", {63'd0, mem_wren}, 64'd0);
      chk("mem_address_idle", {52'd0, mem_address}, 64'd0);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h020] = 32'h11111111;
    mem[12'h021] = 32'h22222222;
    mem[12'h022] = 32'h33333333;
    mem[12'h023] = 32'h44444444;
    mem[12'h0FF] = 32'h0;
    reset = 1'b0;
    set0(1, 1, 1, 12'h055, 32'hA5A5A5A5);
    set1(1, 0, 0, 12'h056, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_gnt", {62'd0, r1_gnt, r0_gnt}, 64'd0);
    chk("rst_rvalid", {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
    chk("rst_mem", {19'd0, mem_wren, mem_address, mem_data}, 64'd0);
    chk("rst_rdata", {r1_rdata, r0_rdata}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    // Contention after reset: alternating grants and back-to-back alternating responses.
    set0(1, 0, 0, 12'h020, 0); set1(1, 0, 0, 12'h021, 0); step(2'b01, 32'h11111111);
    set0(1, 0, 0, 12'h022, 0);                            step(2'b10, 32'h22222222);
    set1(1, 0, 0, 12'h023, 0);                            step(2'b01, 32'h33333333);
                                                          step(2'b10, 32'h44444444);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);             step(2'b00, 0);
    // Lone read by requester 0.
    set0(1, 0, 0, 12'h010, 0);                            step(2'b01, 32'hDEADBEEF);
    set0(0, 0, 0, 0, 0);                                  step(2'b00, 0);
    // Write by requester 1, then read back by requester 0.
    set1(1, 1, 0, 12'h0FF, 32'h12345678);                 step(2'b10, 0);
    set1(0, 0, 0, 0, 0); set0(1, 0, 0, 12'h0FF, 0);       step(2'b01, 32'h12345678);
    set0(0, 0, 0, 0, 0);                                  step(2'b00, 0);
    // Lock expiry: 8 locked grants to r1, r0 gets one cycle, then r1 locks again.
    set1(1, 0, 1, 12'h010, 0); set0(1, 0, 0, 12'h0FF, 0);
    for (int i = 0; i < 8; i++) step(2'b10, 32'hDEADBEEF);
    step(2'b01, 32'h12345678);
    for (int i = 0; i < 3; i++) step(2'b10, 32'hDEADBEEF);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);             step(2'b00, 0);
    // Lock released by req drop; r1 lock while not granted has no effect.
    set0(1, 0, 1, 12'h010, 0); set1(1, 0, 1, 12'h0FF, 0); step(2'b01, 32'hDEADBEEF);
                                                          step(2'b01, 32'hDEADBEEF);
    set0(0, 0, 0, 0, 0); set1(1, 0, 0, 12'h0FF, 0);       step(2'b10, 32'h12345678);
    set0(1, 0, 0, 12'h010, 0);                            step(2'b01, 32'hDEADBEEF);
    // Reset in the middle of a lock with a read outstanding.
    set1(0, 0, 0, 0, 0); set0(1, 0, 1, 12'h010, 0);       step(2'b01, 32'hDEADBEEF);
    set1(1, 0, 0, 12'h021, 0);                            step(2'b01, 32'hDEADBEEF);
                                                          step(2'b01, 32'hDEADBEEF);
    reset = 1'b0;
    #1;
    chk("midrst_gnt", {62'd0, r1_gnt, r0_gnt}, 64'd0);
    chk("midrst_rvalid", {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
    chk("midrst_wren", {63'd0, mem_wren}, 64'd0);
    sb.delete();
    #1;
    reset = 1'b1;
    set0(1, 0, 0, 12'h020, 0); set1(1, 0, 0, 12'h021, 0); step(2'b01, 32'h11111111);
                                                          step(2'b10, 32'h22222222);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);             step(2'b00, 0);
                                                          step(2'b00, 0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port 12-bit-address / 32-bit-data dmem between two requesters. Requester 0 is the processor data port. Requester 1 is a loader/debug DMA port. The block sits between the requesters and the dmem instance, clocked on the processor clock. It provides round-robin arbitration, bounded burst locking, and 1-cycle read-response tagging so each requester receives only its own read data.

Parameters:
ADDR_W, 12, dmem address width
DATA_W, 32, dmem data width
MAX_LOCK, 8, max consecutive cycles one requester may hold a lock (range 1..255)

Ports:
clock  in  1  master clock (processor clock)
reset  in  1  asynchronous, active-low reset
r0_req  in  1  requester 0 access request
r0_we  in  1  requester 0 write (1) / read (0)
r0_lock  in  1  requester 0 requests to keep ownership next cycle
r0_addr  in  ADDR_W  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  requester 0 granted this cycle
r0_rvalid  out  1  r0_rdata valid (read granted previous cycle)
r0_rdata  out  DATA_W  requester 0 read data
r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  (same as requester 0, for requester 1)
mem_address  out  ADDR_W  to dmem address
mem_data  out  DATA_W  to dmem write data
mem_wren  out  1  to dmem write enable
mem_q  in  DATA_W  from dmem read data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, priority pointer = requester 0, lock counter = 0, response tag cleared.
  - r0_gnt, r1_gnt, mem_wren, r0_rvalid, r1_rvalid = 0.
  - mem_address, mem_data, rdata outputs = 0.
- Grant timing:
  - Grants are combinational from the current req inputs and registered state. At most one gnt per cycle; never both.
  - Granted requester's addr/wdata drive mem_address/mem_data. mem_wren = gnt & we. With no grant, mem_wren=0 and mem_address holds 0.
- States:
  - IDLE (no owner): only one req → grant it. Both req → grant the requester indicated by the priority pointer.
  - OWN0 / OWN1 (locked owner): grant the owner if its req=1, regardless of the other requester.
- State transitions, evaluated at the rising clock edge:
  - Granted requester with lock=1 → OWN of that requester. Counter increments (set to 1 on entry).
  - In OWNx with req=0 or lock=0 → IDLE, counter=0.
  - In OWNx with counter==MAX_LOCK → forced to IDLE, counter=0. The pointer is set to the other requester, so on contention the other requester wins next cycle.
- Priority pointer:
  - After any granted cycle, the pointer points to the non-granted requester.
  - Unchanged on idle cycles.
  - Reset priority is requester 0.
- Read response:
  - A granted read (we=0) sets a registered tag (valid + id).
  - Next cycle, rx_rvalid=1 only for the tagged id, and rx_rdata=mem_q. The non-tagged rdata output stays 0.
  - Writes produce no rvalid.
  - Back-to-back reads by alternating requesters yield alternating rvalid with no bubble.
- Simultaneous events:
  - A lock request by the granted requester in the same cycle that the counter expires is ignored (forced release wins).
  - A req with lock=1 from the non-granted requester has no effect.
- Reset mid-operation:
  - An outstanding read tag is dropped; no rvalid after reset deasserts.
  - A lock is released.
  - First arbitration after reset favours requester 0.
- Counter width: 8 bits. No wrap; the counter saturates at MAX_LOCK, where it forces release.

Test Plan:
- r0 read alone: r0_req=1, we=0, addr=0x010 with dmem[0x010]=0xDEADBEEF → r0_gnt=1 same cycle, mem_wren=0; next cycle r0_rvalid=1, r0_rdata=0xDEADBEEF, r1_rvalid=0.
- Contention: both req for 4 cycles, no lock, after reset → grants r0,r1,r0,r1. rvalid follows one cycle later, each with its own addresses' data.
- Write: r1 writes 0x12345678 to 0x0FF → mem_wren=1 only that cycle, no rvalid. A subsequent r0 read of 0x0FF returns 0x12345678.
- Lock expiry (MAX_LOCK=8): r1 req+lock held 12 cycles, r0 req held → r1_gnt for 8 consecutive cycles, then r0_gnt the 9th cycle. r1 may lock again after that.
- Reset mid-lock: r0 locked 3 cycles with a read outstanding, reset pulsed low between edges → all gnt/rvalid/mem_wren drop immediately. After release, both req → r0 granted first.
- Lock released by req drop: r0 lock 2 cycles then r0_req=0 with r1_req=1 → r1_gnt next cycle, state IDLE.
